synch_updown_counter: RTL
=========================

Name: synch_updown_counter

Overview:
- Parametrised successor to the 4-bit synchronous down counter.
- Counts up or down, selectable per cycle, over a programmable modulus 0..MAX_VAL.
- Supports parallel load, count enable, and wrap or saturate mode at the limits.
- Flags the terminal count and a registered wrap event, so instances can be cascaded into timers and prescalers.

Parameters:
- WIDTH, 4: counter width in bits.
- MAX_VAL, 2**WIDTH-1: upper count limit (modulus-1); must satisfy 0 < MAX_VAL <= 2**WIDTH-1.
- SATURATE, 0: 0 = wrap at the limits; 1 = hold at the limits.
- RESET_VAL, 0: value loaded into q on reset; must be <= MAX_VAL.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-low reset.
- en  input  1  count enable.
- load  input  1  parallel load strobe.
- up  input  1  direction: 1 = up, 0 = down.
- d  input  WIDTH  parallel load value.
- q  output  WIDTH  registered count.
- tc  output  1  terminal count (combinational).
- wrap  output  1  registered one-cycle wrap pulse.
- zero  output  1  high when q == 0 (combinational from q).

Behaviour:
- Clocking and reset:
  - One clock, clk; all state updates on the rising edge.
  - Reset is synchronous and active-low on rst; it only takes effect at a clk edge.
  - rst sampled low: q <= RESET_VAL, wrap <= 0. tc and zero follow from q.
- Priority per edge, highest first: rst low > load > en > hold.
- Load (load=1):
  - q <= d; if d > MAX_VAL then q <= MAX_VAL (clamp).
  - wrap <= 0.
  - Load ignores en and up.
- Count (en=1, load=0):
  - up=1, q < MAX_VAL: q <= q+1.
  - up=1, q == MAX_VAL: SATURATE=0 gives q <= 0 and wrap <= 1; SATURATE=1 gives q holds and wrap <= 0.
  - up=0, q > 0: q <= q-1.
  - up=0, q == 0: SATURATE=0 gives q <= MAX_VAL and wrap <= 1; SATURATE=1 gives q holds and wrap <= 0.
- Hold (en=0, load=0): q holds, wrap <= 0.
- wrap:
  - High for exactly the one cycle following a wrapping edge.
  - Consecutive wraps, e.g. MAX_VAL=1 counting continuously, give wrap high on consecutive cycles.
- tc = en & ~load & ((up & q==MAX_VAL) | (~up & q==0)).
  - tc is asserted in both modes; it predicts a wrap or saturation at the next edge.
  - Intended to drive the en of the next cascaded stage.
- Direction change: takes effect at the same edge it is sampled; no extra latency.
- Width rules:
  - All comparisons are unsigned at WIDTH bits.
  - The increment/decrement must not rely on natural 2**WIDTH overflow when MAX_VAL < 2**WIDTH-1; wrap is explicit against MAX_VAL and 0.
- Latency: one cycle from sampled inputs to q; tc and zero are combinational from q, en, load and up.
- Reset mid-count: overrides load and en on that edge; wrap is cleared the same edge.
- Out-of-range state is unreachable by construction. The clamp on load also covers d values above MAX_VAL.

Test Plan:
- Defaults, rst=0 for 2 edges, then rst=1, en=1, up=0 -> q = 0, then 15, 14, 13 …; wrap high for the one cycle after the 0->15 edge; tc high while q=0.
- MAX_VAL=9, SATURATE=0, load d=7 then en=1, up=1 for 5 edges -> q = 7, 8, 9, 0, 1, 2; wrap pulses the cycle q becomes 0; tc high only while q=9.
- MAX_VAL=9, SATURATE=1, load d=1, en=1, up=0 for 4 edges -> q = 1, 0, 0, 0; wrap never asserts; tc high while q=0 and en=1.
- MAX_VAL=9, load=1 with d=4'hC -> q=9 (clamped); load=1 and en=1 together with d=3 -> q=3, no count.
- Count up from 5 with en=1, toggle en=0 for 2 cycles, then up=0 -> q = 5, 6, 6, 6, 5; assert rst=0 mid-count -> q=RESET_VAL on that edge, wrap=0.
- Cascade two defaults instances, with stage-1 tc driving stage-2 en, up=1, run 40 edges -> the combined count {q2,q1} increments by 1 every edge from 0 to 40 (0x28).

Source files
------------

// File: rtl/synch_updown_counter.sv
// Parametrised synchronous up/down counter with programmable modulus, parallel
// load, wrap or saturate at the limits, terminal-count and registered wrap flags.
module synch_updown_counter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_VAL   = 2**WIDTH - 1,
    parameter bit          SATURATE  = 1'b0,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             up,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             zero
);

    localparam logic [WIDTH-1:0] MAX  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RVAL = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] q_next;
    logic             wrap_next;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (q == MAX);
    assign at_zero = (q == '0);

    // Limits are handled explicitly so a modulus below 2**WIDTH never relies
    // on natural overflow of the adder.
    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        if (load) begin
            q_next = (d > MAX) ? MAX : d;
        end else if (en) begin
            if (up) begin
                if (!at_max) begin
                    q_next = q + ONE;
                end else if (!SATURATE) begin
                    q_next    = '0;
                    wrap_next = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    q_next = q - ONE;
                end else if (!SATURATE) begin
                    q_next    = MAX;
                    wrap_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q    <= RVAL;
            wrap <= 1'b0;
        end else begin
            q    <= q_next;
            wrap <= wrap_next;
        end
    end

    // tc predicts a limit event at the next edge; it feeds the next stage's en.
    assign tc   = en & ~load & ((up & at_max) | (~up & at_zero));
    assign zero = at_zero;

endmodule
